// File: rtl/ast_pipe_slice.sv
// Avalon-ST register slice chain: NUM_STAGES cascaded 2-entry skid buffers.
// Optional packet framing checker is built when AST_PKT_CHECK_EN is defined.
module ast_pipe_slice #(
  parameter int DWIDTH     = 32,
  parameter int NUM_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              pkt_err_o
);

  localparam int W = DWIDTH + 2;

  // link i feeds stage i; link NUM_STAGES is the source port
  logic [NUM_STAGES:0][W-1:0] ld;
  logic [NUM_STAGES:0]        lv;
  logic [NUM_STAGES:0]        lr;

  assign ld[0] = {snk_data_i, snk_startofpacket_i, snk_endofpacket_i};
  assign lv[0] = snk_valid_i;
  assign snk_ready_o = lr[0];
  assign lr[NUM_STAGES] = src_ready_i;
  assign {src_data_o, src_startofpacket_o, src_endofpacket_o} = ld[NUM_STAGES];
  assign src_valid_o = lv[NUM_STAGES];

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         main_v;
    logic         skid_v;
    logic         rdy_q;
    logic         main_v_n;
    logic         skid_v_n;
    logic         acc_in;
    logic         acc_out;
    logic         load_main;
    logic         load_skid;
    logic         shift_skid;

    assign acc_in  = lv[i] & rdy_q;
    assign acc_out = main_v & lr[i+1];

    // rdy_q mirrors !skid_v, so accept never coincides with a full skid
    always_comb begin
      main_v_n   = main_v;
      skid_v_n   = skid_v;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      shift_skid = 1'b0;
      if (acc_out) begin
        if (skid_v) begin
          shift_skid = 1'b1;
          skid_v_n   = 1'b0;
        end else if (acc_in) begin
          load_main = 1'b1;
        end else begin
          main_v_n = 1'b0;
        end
      end else if (acc_in) begin
        if (main_v) begin
          load_skid = 1'b1;
          skid_v_n  = 1'b1;
        end else begin
          load_main = 1'b1;
          main_v_n  = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
        rdy_q  <= 1'b0;
      end else begin
        main_v <= main_v_n;
        skid_v <= skid_v_n;
        rdy_q  <= !skid_v_n;
      end
    end

    always_ff @(posedge clk_i) begin
      if (load_main) begin
        main_q <= ld[i];
      end else if (shift_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= ld[i];
      end
    end

    assign ld[i+1] = main_q;
    assign lv[i+1] = main_v;
    assign lr[i]   = rdy_q;
  end

`ifdef AST_PKT_CHECK_EN
  logic in_pkt;
  logic err_q;
  logic snk_acc;

  assign snk_acc = snk_valid_i & snk_ready_o;

  // sop must arrive exactly when no packet is open
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      in_pkt <= 1'b0;
      err_q  <= 1'b0;
    end else if (snk_acc) begin
      if (snk_startofpacket_i == in_pkt) begin
        err_q <= 1'b1;
      end
      in_pkt <= !snk_endofpacket_i & (snk_startofpacket_i | in_pkt);
    end
  end

  assign pkt_err_o = err_q;
`else
  assign pkt_err_o = 1'b0;
`endif

endmodule
